mem_req_ctrl: RTL

Clocked initiator for the asynchronous memory request/finish interface: `re`/`we`, separate read and write addresses, and `r_finished`/`w_finished` level handshakes. It accepts one read or write request at a time from a pipeline stage over valid/ready. It drives the memory port, synchronizes the finish lines, captures read data, and returns a response over valid/ready. It sits between the fetch/load-store stages and any memory model or cache that uses that interface.

---
 rtl/mem_req_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: single-outstanding initiator for the async re/we memory port.
// Optional macro: MEM_REQ_CTRL_TIMEOUT_EN (abort ISSUE/BUSY after TIMEOUT_CYCLES).
// Ports: clk, rst_n; req_* (valid/ready request in), resp_* (valid/ready
// response out), mem_* (memory enables, addresses, data, async finish lines).
module mem_req_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [31:0] mem_r_addr_o,
    output logic [31:0] mem_w_addr_o,
    output logic [31:0] mem_d_in_o,
    input  logic [31:0] mem_d_out_i,
    input  logic        mem_r_finished_i,
    input  logic        mem_w_finished_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [31:0] d_in_q, d_in_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rf_meta_q, rf_s_q;
    logic        wf_meta_q, wf_s_q;
    logic        fin_s;
    logic        accept;
    logic        active;
    logic        timeout_hit;

    // Finish lines are asynchronous; idle level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_meta_q <= 1'b1;
            rf_s_q    <= 1'b1;
            wf_meta_q <= 1'b1;
            wf_s_q    <= 1'b1;
        end else begin
            rf_meta_q <= mem_r_finished_i;
            rf_s_q    <= rf_meta_q;
            wf_meta_q <= mem_w_finished_i;
            wf_s_q    <= wf_meta_q;
        end
    end

    assign fin_s  = we_q ? wf_s_q : rf_s_q;
    assign accept = (state_q == S_IDLE) && req_valid_i;
    assign active = (state_q == S_ISSUE) || (state_q == S_BUSY);

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;

    assign timeout_hit = active && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if (active) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign resp_err_o = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
    assign resp_err_o         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        r_addr_d = r_addr_q;
        w_addr_d = w_addr_q;
        d_in_d   = d_in_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d = req_we_i;
                    if (req_we_i) begin
                        w_addr_d = req_addr_i;
                        d_in_d   = req_wdata_i;
                    end else begin
                        r_addr_d = req_addr_i;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (timeout_hit) begin
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (!fin_s) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (timeout_hit) begin
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (fin_s) begin
                    // Raw rise is at least two edges old here, so data is settled.
                    rdata_d = we_q ? 32'd0 : mem_d_out_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            r_addr_q <= '0;
            w_addr_q <= '0;
            d_in_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            r_addr_q <= r_addr_d;
            w_addr_q <= w_addr_d;
            d_in_q   <= d_in_d;
            rdata_q  <= rdata_d;
        end
    end

    // Enables come straight from state flops; they are low in IDLE and DONE,
    // so addresses only ever change while the memory is disabled.
    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_DONE);
    assign resp_rdata_o = rdata_q;
    assign mem_re_o     = active && !we_q;
    assign mem_we_o     = active && we_q;
    assign mem_r_addr_o = r_addr_q;
    assign mem_w_addr_o = w_addr_q;
    assign mem_d_in_o   = d_in_q;

endmodule
